// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the
// load/store stage, one transaction at a time, with a response timeout.
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  output logic                if_rsp_err,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                d_rsp_err,

  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                timeout,
  output logic [1:0]          fsm_state
);

  // Handshake: a request transfers in the cycle where valid and ready are both
  // high; ready is only ever high in IDLE and only for the arbitration winner.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic       own_d_q;        // owner of the in-flight transaction: 1 = data
  logic       prio_fetch_q;   // 1 = fetch wins the next tie
  logic [7:0] cnt_q;
  logic       grant_if, grant_d, accept, rsp_fire, to_fire;

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    rsp_fire = 1'b0;
    to_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst) begin
          if (d_req_valid && (!if_req_valid || !prio_fetch_q)) grant_d = 1'b1;
          else if (if_req_valid)                                grant_if = 1'b1;
          if (grant_d || grant_if) state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Timeout wins over an rvalid arriving in the same cycle.
        if (cnt_q == LAST_CNT) begin
          to_fire = 1'b1;
          state_d = S_IDLE;
        end else if (mem_rvalid) begin
          rsp_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept       = grant_if | grant_d;
  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;
  assign timeout      = to_fire;
  assign mem_req      = (state_q == S_REQ);
  assign fsm_state    = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_d_q      <= 1'b0;
      prio_fetch_q <= 1'b0;
      cnt_q        <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;

      if (accept) begin
        own_d_q      <= grant_d;
        prio_fetch_q <= grant_d;
        mem_addr     <= grant_d ? d_addr : if_addr;
        mem_we       <= grant_d & d_we;
        mem_wdata    <= grant_d ? d_wdata : '0;
        mem_wstrb    <= grant_d ? d_wstrb : '0;
      end

      if (state_q == S_REQ && mem_gnt) cnt_q <= '0;
      else if (state_q == S_WAIT)      cnt_q <= cnt_q + 8'd1;

      if (rsp_fire || to_fire) begin
        if (own_d_q) begin
          d_rsp_valid <= 1'b1;
          d_rsp_err   <= to_fire;
          d_rsp_data  <= to_fire ? '1 : (mem_we ? '0 : mem_rdata);
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_err   <= to_fire;
          if_rsp_data  <= to_fire ? '1 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the memory side is driven step by step
// and every response is matched against a queue of expected responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 15;
  localparam int EW       = DATA_W + 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                if_req_valid = 1'b0;
  logic                if_req_ready;
  logic [ADDR_W-1:0]   if_addr = '0;
  logic                if_rsp_valid;
  logic [DATA_W-1:0]   if_rsp_data;
  logic                if_rsp_err;
  logic                d_req_valid = 1'b0;
  logic                d_req_ready;
  logic [ADDR_W-1:0]   d_addr = '0;
  logic                d_we = 1'b0;
  logic [DATA_W-1:0]   d_wdata = '0;
  logic [DATA_W/8-1:0] d_wstrb = '0;
  logic                d_rsp_valid;
  logic [DATA_W-1:0]   d_rsp_data;
  logic                d_rsp_err;
  logic                mem_req;
  logic                mem_gnt = 1'b0;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_rvalid = 1'b0;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic                timeout;
  logic [1:0]          fsm_state;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .timeout(timeout), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Expected response: {d_rsp_valid, if_rsp_valid, err, data}
  logic [EW-1:0] exp_q[$];

  logic                exp_d;
  logic [ADDR_W-1:0]   exp_addr;
  logic                exp_we;
  logic [DATA_W-1:0]   exp_wdata;
  logic [DATA_W/8-1:0] exp_wstrb;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every response pulse pops one expectation
  always @(negedge clk) begin
    if (rst && (if_rsp_valid || d_rsp_valid)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {d_rsp_valid, if_rsp_valid}, '0);
      end else begin
        check("rsp", {d_rsp_valid, if_rsp_valid,
                      d_rsp_valid ? d_rsp_err : if_rsp_err,
                      d_rsp_valid ? d_rsp_data : if_rsp_data}, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge in IDLE with the request inputs already driven.
  task automatic accept(input logic is_d);
    #1;
    check("if_ready", if_req_ready, !is_d);
    check("d_ready", d_req_ready, is_d);
    check("state_idle", fsm_state, 2'd0);
    exp_d     = is_d;
    exp_addr  = is_d ? d_addr : if_addr;
    exp_we    = is_d & d_we;
    exp_wdata = is_d ? d_wdata : '0;
    exp_wstrb = is_d ? d_wstrb : '0;
    @(negedge clk);
  endtask

  // Called at the negedge of the first REQ cycle; returns at the IDLE cycle
  // that carries the response pulse.
  task automatic serve(input int gnt_delay, input int rv_delay, input logic [DATA_W-1:0] rdata);
    for (int g = 0; g <= gnt_delay; g++) begin
      mem_gnt = (g == gnt_delay);
      #1;
      check("mem_req", mem_req, 1'b1);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_we", mem_we, exp_we);
      check("mem_wdata", mem_wdata, exp_wdata);
      check("mem_wstrb", mem_wstrb, exp_wstrb);
      check("ready_in_req", {if_req_ready, d_req_ready}, '0);
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    for (int w = 0; w <= rv_delay; w++) begin
      mem_rvalid = (w == rv_delay);
      mem_rdata  = (w == rv_delay) ? rdata : 64'hBAD0_BAD0_BAD0_BAD0;
      if (w == rv_delay) exp_q.push_back({exp_d, ~exp_d, 1'b0, exp_we ? 64'd0 : rdata});
      #1;
      check("mem_req_wait", mem_req, 1'b0);
      check("ready_in_wait", {if_req_ready, d_req_ready}, '0);
      check("state_wait", fsm_state, 2'd2);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rsp", {if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}, '0);
    check("rst_rsp_data", {if_rsp_data, d_rsp_data}, '0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst = 1'b1;

    // single fetch
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h40;
    accept(1'b0);
    if_req_valid = 1'b0;
    serve(0, 2, 64'h0000_0013);
    #1;
    check("fetch_pulse", if_rsp_valid, 1'b1);
    check("fetch_data", if_rsp_data, 64'h13);
    check("fetch_no_d", d_rsp_valid, 1'b0);
    @(negedge clk); #1;
    check("fetch_one_pulse", if_rsp_valid, 1'b0);

    // simultaneous requests: data, fetch, data, fetch
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h100;
    d_req_valid = 1'b1; d_addr = 64'h200; d_we = 1'b0; d_wdata = 64'h1111; d_wstrb = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      accept(k % 2 == 0);
      serve(1, 0, 64'hA0 + 64'(k));
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;

    // store
    @(negedge clk);
    d_req_valid = 1'b1; d_addr = 64'h8; d_we = 1'b1; d_wdata = 64'hDEADBEEF; d_wstrb = 8'h0F;
    accept(1'b1);
    d_req_valid = 1'b0;
    serve(0, 0, 64'h5555);

    // delayed grant with a pending data request held off
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h80;
    accept(1'b0);
    if_req_valid = 1'b0;
    d_req_valid = 1'b1; d_addr = 64'h300; d_we = 1'b0; d_wdata = 64'h2222; d_wstrb = 8'h33;
    serve(5, 0, 64'h77);
    accept(1'b1);
    d_req_valid = 1'b0;
    serve(0, 1, 64'h88);

    // timeout, with rvalid on the timeout cycle and one afterwards
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'hC0;
    accept(1'b0);
    if_req_valid = 1'b0;
    mem_gnt = 1'b1; #1;
    check("to_mem_req", mem_req, 1'b1);
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      if (i == MAX_WAIT) begin
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        exp_q.push_back({1'b0, 1'b1, 1'b1, {DATA_W{1'b1}}});
      end
      #1;
      check("timeout_pulse", timeout, i == MAX_WAIT);
      check("to_state_wait", fsm_state, 2'd2);
      @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = 64'h5678;
    #1;
    check("to_err", {if_rsp_valid, if_rsp_err}, 2'b11);
    check("to_data", if_rsp_data, {DATA_W{1'b1}});
    check("to_pulse_once", timeout, 1'b0);
    check("to_state_idle", fsm_state, 2'd0);
    @(negedge clk);
    mem_rvalid = 1'b0; #1;
    check("to_rsp_clear", {if_rsp_valid, if_rsp_err, d_rsp_valid}, '0);

    // reset during WAIT after a data win
    @(negedge clk);
    d_req_valid = 1'b1; d_addr = 64'h500; d_we = 1'b0;
    accept(1'b1);
    d_req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; #1;
    check("pre_rst_wait", fsm_state, 2'd2);
    #1 rst = 1'b0;
    #1;
    check("arst_state", fsm_state, 2'd0);
    check("arst_mem", {mem_req, mem_we}, '0);
    check("arst_addr", mem_addr, '0);
    check("arst_rsp", {if_rsp_valid, d_rsp_valid, timeout}, '0);
    mem_rvalid = 1'b1; mem_rdata = 64'h9999;
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_no_rsp", {if_rsp_valid, d_rsp_valid}, '0);
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h600;
    d_req_valid = 1'b1; d_addr = 64'h700; d_we = 1'b0;
    accept(1'b1);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    serve(0, 0, 64'h99);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
